// File: rtl/latency_ram.sv
// +--------------------------------------------------------------------------+
// | latency_ram: byte-addressed data memory, independent read/write channels |
// |              with fixed per-channel access latency.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module latency_ram #(
  parameter int DATA_BYTES    = 4,
  parameter int DEPTH_BYTES   = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int READ_LATENCY  = 10,
  parameter int WRITE_LATENCY = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_busy,
  output logic                    rd_valid,
  output logic [8*DATA_BYTES-1:0] rd_data,
  output logic                    rd_err,
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [8*DATA_BYTES-1:0] wr_data,
  input  logic [DATA_BYTES-1:0]   wr_be,
  output logic                    wr_busy,
  output logic                    wr_done,
  output logic                    wr_err
);

  localparam int c_DATA_W   = 8 * DATA_BYTES;
  localparam int c_IDX_W    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int c_EXT_W    = ADDR_WIDTH + 1;
  localparam int c_RD_CNT_W = $clog2(READ_LATENCY + 1);
  localparam int c_WR_CNT_W = $clog2(WRITE_LATENCY + 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_WAIT = 1'b1;

  logic [7:0] r_mem [DEPTH_BYTES];

  // ---------------- read channel ----------------
  logic [0:0]            r_rdState, w_rdNext;
  logic [c_RD_CNT_W-1:0] r_rdCnt;
  logic [ADDR_WIDTH-1:0] r_rdAddr;
  logic                  w_rdAccept, w_rdFire, w_rdInRange;
  logic [c_DATA_W-1:0]   w_rdWord;

  assign w_rdAccept  = (r_rdState == c_IDLE) && rd_req;
  assign w_rdFire    = (r_rdState == c_WAIT) && (r_rdCnt == c_RD_CNT_W'(READ_LATENCY));
  // Extended by one bit so the bound check cannot wrap near the top of the address space.
  assign w_rdInRange = ({1'b0, r_rdAddr} + c_EXT_W'(DATA_BYTES)) <= c_EXT_W'(DEPTH_BYTES);

  always_ff @(posedge clk) begin
    if (rst) r_rdState <= c_IDLE;
    else     r_rdState <= w_rdNext;
  end

  always_comb begin
    w_rdNext = r_rdState;
    case (r_rdState)
      c_IDLE:  if (rd_req)   w_rdNext = c_WAIT;
      c_WAIT:  if (w_rdFire) w_rdNext = c_IDLE;
      default: w_rdNext = c_IDLE;
    endcase
  end

  always_comb begin
    rd_busy = (r_rdState == c_WAIT);
  end

  // Big-endian: lowest address lands in the most significant byte.
  always_comb begin
    w_rdWord = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      w_rdWord[8*(DATA_BYTES-1-i) +: 8] = r_mem[c_IDX_W'(r_rdAddr) + c_IDX_W'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdCnt  <= '0;
      r_rdAddr <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= w_rdFire;
      if (w_rdAccept) begin
        r_rdCnt  <= c_RD_CNT_W'(1);
        r_rdAddr <= rd_addr;
      end else if (w_rdFire) begin
        r_rdCnt  <= '0;
      end else if (r_rdState == c_WAIT) begin
        r_rdCnt  <= r_rdCnt + c_RD_CNT_W'(1);
      end
      if (w_rdFire) begin
        rd_data <= w_rdInRange ? w_rdWord : '0;
        rd_err  <= ~w_rdInRange;
      end
    end
  end

  // ---------------- write channel ----------------
  logic [0:0]            r_wrState, w_wrNext;
  logic [c_WR_CNT_W-1:0] r_wrCnt;
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic [c_DATA_W-1:0]   r_wrData;
  logic [DATA_BYTES-1:0] r_wrBe;
  logic                  w_wrAccept, w_wrFire, w_wrInRange;

  assign w_wrAccept  = (r_wrState == c_IDLE) && wr_req;
  assign w_wrFire    = (r_wrState == c_WAIT) && (r_wrCnt == c_WR_CNT_W'(WRITE_LATENCY));
  assign w_wrInRange = ({1'b0, r_wrAddr} + c_EXT_W'(DATA_BYTES)) <= c_EXT_W'(DEPTH_BYTES);

  always_ff @(posedge clk) begin
    if (rst) r_wrState <= c_IDLE;
    else     r_wrState <= w_wrNext;
  end

  always_comb begin
    w_wrNext = r_wrState;
    case (r_wrState)
      c_IDLE:  if (wr_req)   w_wrNext = c_WAIT;
      c_WAIT:  if (w_wrFire) w_wrNext = c_IDLE;
      default: w_wrNext = c_IDLE;
    endcase
  end

  always_comb begin
    wr_busy = (r_wrState == c_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrCnt  <= '0;
      r_wrAddr <= '0;
      r_wrData <= '0;
      r_wrBe   <= '0;
      wr_done  <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      wr_done <= w_wrFire;
      if (w_wrAccept) begin
        r_wrCnt  <= c_WR_CNT_W'(1);
        r_wrAddr <= wr_addr;
        r_wrData <= wr_data;
        r_wrBe   <= wr_be;
      end else if (w_wrFire) begin
        r_wrCnt  <= '0;
      end else if (r_wrState == c_WAIT) begin
        r_wrCnt  <= r_wrCnt + c_WR_CNT_W'(1);
      end
      if (w_wrFire) wr_err <= ~w_wrInRange;
    end
  end

  // Memory is never reset; a reset coinciding with the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && w_wrFire && w_wrInRange) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (r_wrBe[DATA_BYTES-1-i])
          r_mem[c_IDX_W'(r_wrAddr) + c_IDX_W'(i)] <= r_wrData[8*(DATA_BYTES-1-i) +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_latency_ram.sv
// +--------------------------------------------------------------------------+
// | tb_latency_ram: directed self-checking bench for latency_ram.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_latency_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdReq, wrReq;
  logic [31:0] rdAddr, wrAddr, wrData;
  logic [3:0]  wrBe;

  logic        rdBusy, rdValid, rdErr, wrBusy, wrDone, wrErr;
  logic [31:0] rdData;
  logic        fRdBusy, fRdValid, fRdErr, fWrBusy, fWrDone, fWrErr;
  logic [31:0] fRdData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  latency_ram dut (
    .clk(clk), .rst(rst),
    .rd_req(rdReq), .rd_addr(rdAddr), .rd_busy(rdBusy), .rd_valid(rdValid),
    .rd_data(rdData), .rd_err(rdErr),
    .wr_req(wrReq), .wr_addr(wrAddr), .wr_data(wrData), .wr_be(wrBe),
    .wr_busy(wrBusy), .wr_done(wrDone), .wr_err(wrErr)
  );

  // Shares inputs with dut; only its outputs are inspected in the short-latency case.
  latency_ram #(.READ_LATENCY(1), .WRITE_LATENCY(3)) dutFast (
    .clk(clk), .rst(rst),
    .rd_req(rdReq), .rd_addr(rdAddr), .rd_busy(fRdBusy), .rd_valid(fRdValid),
    .rd_data(fRdData), .rd_err(fRdErr),
    .wr_req(wrReq), .wr_addr(wrAddr), .wr_data(wrData), .wr_be(wrBe),
    .wr_busy(fWrBusy), .wr_done(fWrDone), .wr_err(fWrErr)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic doWrite(input bit fast, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, output int lat, output logic err);
    @(negedge clk);
    wrReq = 1'b1; wrAddr = addr; wrData = data; wrBe = be;
    @(posedge clk); #1;
    checkVal("wrBusyAfterAccept", {31'd0, fast ? fWrBusy : wrBusy}, 32'd1);
    @(negedge clk);
    wrReq = 1'b0; wrAddr = addr ^ 32'd4; wrData = ~data; wrBe = ~be;
    lat = 0; err = 1'b0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (fast ? fWrDone : wrDone) begin
        err = fast ? fWrErr : wrErr;
        break;
      end
    end
  endtask

  task automatic doRead(input bit fast, input logic [31:0] addr, output int lat,
                        output logic [31:0] data, output logic err);
    @(negedge clk);
    rdReq = 1'b1; rdAddr = addr;
    @(posedge clk); #1;
    checkVal("rdBusyAfterAccept", {31'd0, fast ? fRdBusy : rdBusy}, 32'd1);
    @(negedge clk);
    rdReq = 1'b0; rdAddr = 32'hFFFF_FFF0;
    lat = 0; data = '0; err = 1'b0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (fast ? fRdValid : rdValid) begin
        data = fast ? fRdData : rdData;
        err  = fast ? fRdErr : rdErr;
        break;
      end
    end
  endtask

  initial begin
    int          lat, n, first, second, rdLat, wrLat;
    logic        err, sawDone;
    logic [31:0] data;

    rst = 1'b1; rdReq = 1'b0; wrReq = 1'b0;
    rdAddr = '0; wrAddr = '0; wrData = '0; wrBe = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("resetRd", {rdBusy, rdValid, rdErr, rdData}, 35'd0);
    checkVal("resetWr", {29'd0, wrBusy, wrDone, wrErr}, 32'd0);
    rst = 1'b0;

    // Preloads
    doWrite(0, 32'd12, 32'h7766_5544, 4'hF, lat, err);
    doWrite(0, 32'd60, 32'h0102_0304, 4'hF, lat, err);
    doWrite(0, 32'd4,  32'h0A0B_0C0D, 4'hF, lat, err);

    doWrite(0, 32'd8, 32'hDEAD_BEEF, 4'hF, lat, err);
    checkVal("wrLatency", lat, 10);
    checkVal("wrErrOk", {31'd0, err}, 32'd0);
    checkVal("wrBusyAtDone", {31'd0, wrBusy}, 32'd0);
    doRead(0, 32'd8, lat, data, err);
    checkVal("rdLatency", lat, 10);
    checkVal("rdData8", data, 32'hDEAD_BEEF);
    checkVal("rdErrOk", {31'd0, err}, 32'd0);
    checkVal("rdBusyAtValid", {31'd0, rdBusy}, 32'd0);
    doRead(0, 32'd9, lat, data, err);
    checkVal("rdUnaligned9", data, 32'hADBE_EF77);

    // Byte enables; bus is scrambled during WAIT by doWrite
    doWrite(0, 32'd8, 32'h1122_3344, 4'b0101, lat, err);
    doRead(0, 32'd8, lat, data, err);
    checkVal("rdByteEnable", data, 32'hDE22_BE44);
    checkVal("rdHoldsData", rdData, 32'hDE22_BE44);
    doWrite(0, 32'd8, 32'hFFFF_FFFF, 4'h0, lat, err);
    checkVal("wrBeZeroLatency", lat, 10);

    // Held read request: reissued one edge after the valid cycle
    @(negedge clk);
    rdReq = 1'b1; rdAddr = 32'd8;
    n = 0; first = 0; second = 0;
    while (n < 100 && second == 0) begin
      @(posedge clk); #1;
      n++;
      if (rdValid) begin
        if (first == 0) first = n;
        else            second = n;
      end
    end
    @(negedge clk);
    rdReq = 1'b0;
    checkVal("heldFirst", first, 11);
    checkVal("heldGap", second - first, 11);
    checkVal("heldData", rdData, 32'hDE22_BE44);

    // Out of range
    doRead(0, 32'd61, lat, data, err);
    checkVal("oorRdLatency", lat, 10);
    checkVal("oorRdErr", {31'd0, err}, 32'd1);
    checkVal("oorRdData", data, 32'd0);
    doWrite(0, 32'd61, 32'hFFFF_FFFF, 4'hF, lat, err);
    checkVal("oorWrLatency", lat, 10);
    checkVal("oorWrErr", {31'd0, err}, 32'd1);
    doRead(0, 32'd60, lat, data, err);
    checkVal("oorMemUnchanged", data, 32'h0102_0304);
    checkVal("rdErrCleared", {31'd0, err}, 32'd0);

    // Collision: read sees pre-write contents
    doWrite(0, 32'd0, 32'hAAAA_AAAA, 4'hF, lat, err);
    @(negedge clk);
    rdReq = 1'b1; rdAddr = 32'd0;
    wrReq = 1'b1; wrAddr = 32'd0; wrData = 32'h5555_5555; wrBe = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    rdReq = 1'b0; wrReq = 1'b0;
    n = 0; rdLat = 0; wrLat = 0; data = '0;
    while (n < 100 && (rdLat == 0 || wrLat == 0)) begin
      @(posedge clk); #1;
      n++;
      if (rdValid && rdLat == 0) begin rdLat = n; data = rdData; end
      if (wrDone && wrLat == 0) wrLat = n;
    end
    checkVal("collRdLatency", rdLat, 10);
    checkVal("collWrLatency", wrLat, 10);
    checkVal("collPreWrite", data, 32'hAAAA_AAAA);
    doRead(0, 32'd0, lat, data, err);
    checkVal("collPostWrite", data, 32'h5555_5555);

    // Reset at counter=5 aborts the write
    @(negedge clk);
    wrReq = 1'b1; wrAddr = 32'd4; wrData = 32'hFFFF_FFFF; wrBe = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    wrReq = 1'b0;
    sawDone = 1'b0;
    repeat (4) begin @(posedge clk); #1; sawDone |= wrDone; end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkVal("rstAbortBusy", {31'd0, wrBusy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) begin @(posedge clk); #1; sawDone |= wrDone; end
    checkVal("rstNoDone", {31'd0, sawDone}, 32'd0);
    doRead(0, 32'd4, lat, data, err);
    checkVal("rstMemUnchanged", data, 32'h0A0B_0C0D);
    checkVal("rstNextLatency", lat, 10);

    // Short-latency instance
    doWrite(1, 32'd8, 32'hDEAD_BEEF, 4'hF, lat, err);
    checkVal("fastWrLatency", lat, 3);
    doRead(1, 32'd8, lat, data, err);
    checkVal("fastRdLatency", lat, 1);
    checkVal("fastRdData", data, 32'hDEAD_BEEF);

    repeat (12) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
